// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: LDM/STM multi-register transfer engine.
// Walks a 16-bit register list lowest index first, one register per memory
// handshake, then optionally writes back the updated base register.
//
// state  | meaning
// IDLE   | waiting for start; all outputs quiet
// XFER   | one memory beat per accepted handshake
// WB     | single-cycle base register writeback
// DONE   | one-cycle completion pulse, still busy
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        base_reg,
  input  logic [1:0]        mode,
  input  logic              is_load,
  input  logic              wb_en,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        rf_read_num,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [3:0]        rf_write_num,
  output logic [DATA_W-1:0] rf_write_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  logic [1:0]        state;
  logic [15:0]       mask_q;
  logic [15:0]       list_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] final_q;
  logic [3:0]        base_reg_q;
  logic              is_load_q;
  logic              wb_en_q;

  logic [4:0]        n;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] final_addr;
  logic [3:0]        cur;
  logic              found;
  logic [15:0]       mask_next;
  logic              hs;
  logic              take_wb;

  // Register count and the address window it spans, from the live inputs.
  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(reg_list[i]);
    span = ADDR_W'({n, 2'b00});
    // Lowest register always lands at the lowest address, so decrementing
    // modes start at the bottom of the window and still count upward.
    case (mode)
      2'b00:   start_addr = base_addr - span + WORD;
      2'b01:   start_addr = base_addr;
      2'b10:   start_addr = base_addr - span;
      default: start_addr = base_addr + WORD;
    endcase
    final_addr = mode[0] ? (base_addr + span) : (base_addr - span);
  end

  // Lowest set bit of the remaining mask is the register for this beat.
  always_comb begin
    cur   = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mask_q[i] && !found) begin
        cur   = 4'(i);
        found = 1'b1;
      end
    end
  end

  assign hs        = (state == S_XFER) && mem_ready;
  assign mask_next = mask_q & ~(16'h0001 << cur);
  // A load that includes the base register keeps the loaded value.
  assign take_wb   = wb_en_q && !(is_load_q && list_q[base_reg_q]);

  // Output decode; everything idles at zero outside the active states.
  always_comb begin
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    mem_req       = (state == S_XFER);
    mem_addr      = mem_req ? addr_q : '0;
    mem_we        = mem_req && !is_load_q;
    mem_wdata     = rf_read_data;
    rf_read_num   = mem_req ? cur : '0;
    rf_write_en   = 1'b0;
    rf_write_num  = '0;
    rf_write_data = '0;
    if (hs && is_load_q) begin
      rf_write_en   = 1'b1;
      rf_write_num  = cur;
      rf_write_data = mem_rdata;
    end else if (state == S_WB) begin
      rf_write_en   = 1'b1;
      rf_write_num  = base_reg_q;
      rf_write_data = DATA_W'(final_q);
    end
  end

  // Sequencer state, latched operands and beat address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      list_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      base_reg_q <= '0;
      is_load_q  <= 1'b0;
      wb_en_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q     <= reg_list;
            list_q     <= reg_list;
            addr_q     <= start_addr;
            final_q    <= final_addr;
            base_reg_q <= base_reg;
            is_load_q  <= is_load;
            wb_en_q    <= wb_en;
            state      <= (n != '0) ? S_XFER : S_DONE;
          end
        end
        S_XFER: begin
          if (mem_ready) begin
            mask_q <= mask_next;
            addr_q <= addr_q + WORD;
            if (mask_next == '0) state <= take_wb ? S_WB : S_DONE;
          end
        end
        S_WB:    state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed and randomized checks of the LDM/STM sequencer
// against a transaction-level model of the expected beats and writeback.
module tb_ldm_stm_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [3:0]  base_reg;
  logic [1:0]  mode;
  logic        is_load;
  logic        wb_en;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [3:0]  rf_read_num;
  logic [31:0] rf_read_data;
  logic        rf_write_en;
  logic [3:0]  rf_write_num;
  logic [31:0] rf_write_data;

  ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .reg_list(reg_list),
    .base_addr(base_addr), .base_reg(base_reg), .mode(mode), .is_load(is_load),
    .wb_en(wb_en), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rf_read_num(rf_read_num),
    .rf_read_data(rf_read_data), .rf_write_en(rf_write_en),
    .rf_write_num(rf_write_num), .rf_write_data(rf_write_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] rf_mem [16];
  assign rf_read_data = rf_mem[rf_read_num];

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  rnum;
    logic [31:0] rdata;
    logic        wen;
    logic [3:0]  wnum;
    logic [31:0] wrf;
  } beat_t;

  typedef struct packed {
    logic [3:0]  num;
    logic [31:0] data;
  } wr_t;

  beat_t beats[$];
  wr_t   wbs[$];
  int    last_hs, done_cycle, done_count, busy_cycles, req_cycles, unstable;
  logic  busy_after;
  bit    timed_out;

  int errors = 0;
  int checks = 0;

  // Runs one transfer, recording every handshake, every non-beat register
  // write and the completion timing relative to the start edge (cycle 0).
  // stall: 0 = always ready, 1 = random ready, 2 = ready every third cycle.
  task automatic drive_op(input logic [15:0] lst, input logic [31:0] base,
                          input logic [3:0] breg, input logic [1:0] md,
                          input logic ld, input logic wb, input int stall,
                          input bit extra_start, input bit ramp);
    int c;
    bit finished;
    bit held_valid;
    logic [31:0] held_addr;
    beat_t b;
    wr_t w;
    beats.delete();
    wbs.delete();
    last_hs = 0; done_cycle = 0; done_count = 0; busy_cycles = 0;
    req_cycles = 0; unstable = 0; busy_after = 1'bx;
    held_valid = 0; held_addr = '0;
    @(negedge clock);
    reg_list = lst; base_addr = base; base_reg = breg; mode = md;
    is_load = ld; wb_en = wb; start = 1'b1; mem_ready = 1'b0;
    c = 0;
    finished = 0;
    while (!finished && c < 300) begin
      @(negedge clock);
      c++;
      start = 1'b0;
      if (extra_start && c == 2) begin
        start = 1'b1; reg_list = ~lst; base_addr = base ^ 32'h0000_FFF0;
        mode = ~md; is_load = ~ld; wb_en = ~wb; base_reg = ~breg;
      end
      case (stall)
        0:       mem_ready = 1'b1;
        1:       mem_ready = 1'($urandom_range(0, 1));
        default: mem_ready = (c % 3 == 0);
      endcase
      mem_rdata = ramp ? (32'hA0 + 32'(beats.size())) : $urandom;
      #1;
      if (held_valid && (!mem_req || mem_addr !== held_addr)) unstable++;
      held_valid = 0;
      if (mem_req && !mem_ready) begin
        held_valid = 1;
        held_addr  = mem_addr;
      end
      if (mem_req) req_cycles++;
      if (mem_req && mem_ready) begin
        b.addr = mem_addr; b.we = mem_we; b.wdata = mem_wdata; b.rnum = rf_read_num;
        b.rdata = mem_rdata; b.wen = rf_write_en; b.wnum = rf_write_num;
        b.wrf = rf_write_data;
        beats.push_back(b);
        last_hs = c;
      end else if (rf_write_en) begin
        w.num = rf_write_num; w.data = rf_write_data;
        wbs.push_back(w);
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_count++;
        if (done_cycle == 0) done_cycle = c;
      end
      if (done_cycle != 0 && c == done_cycle + 1) begin
        busy_after = busy;
        finished = 1;
      end
    end
    timed_out = !finished;
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Reference model: address window from the transfer rules.
  function automatic logic [31:0] model_start(input logic [31:0] base,
                                               input logic [1:0] md, input int n);
    logic [31:0] sp;
    sp = 32'(n * 4);
    case (md)
      2'b00:   return base - sp + 32'd4;
      2'b01:   return base;
      2'b10:   return base - sp;
      default: return base + 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] model_final(input logic [31:0] base,
                                               input logic [1:0] md, input int n);
    return (md == 2'b01 || md == 2'b11) ? base + 32'(n * 4) : base - 32'(n * 4);
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    reg_list = 16'hFFFF; base_addr = 32'h1234; base_reg = 4'd5; mode = 2'b01;
    is_load = 1'b1; wb_en = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({busy, done, mem_req, mem_we, rf_write_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_req, mem_we, rf_write_en});
    end
    checks++;
    if ({mem_addr, rf_read_num, rf_write_num, rf_write_data} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h rnum=%h wnum=%h wdata=%h want all 0",
               mem_addr, rf_read_num, rf_write_num, rf_write_data);
    end
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_stm_ia();
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'h1100_0000 + 32'(i);
    drive_op(16'h000E, 32'h1000, 4'd13, 2'b01, 1'b0, 1'b1, 0, 0, 0);
    checks++;
    if (beats.size() != 3) begin
      errors++; $display("FAIL stm_ia_beats: got %0d want 3", beats.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (beats[k].addr !== 32'h1000 + 32'(4 * k) || beats[k].wdata !== rf_mem[k + 1] ||
            beats[k].we !== 1'b1 || beats[k].wen !== 1'b0) begin
          errors++;
          $display("FAIL stm_ia_beat%0d: addr=%h data=%h we=%b wen=%b want addr=%h data=%h we=1 wen=0",
                   k, beats[k].addr, beats[k].wdata, beats[k].we, beats[k].wen,
                   32'h1000 + 32'(4 * k), rf_mem[k + 1]);
        end
      end
    end
    checks++;
    if (wbs.size() != 1 || wbs[0].num !== 4'd13 || wbs[0].data !== 32'h100C) begin
      errors++;
      $display("FAIL stm_ia_wb: writes=%0d num=%0d data=%h want 1 write R13=0000100c",
               wbs.size(), wbs.size() > 0 ? wbs[0].num : 4'd0, wbs.size() > 0 ? wbs[0].data : 32'h0);
    end
    checks++;
    if (done_cycle != 5 || timed_out) begin
      errors++; $display("FAIL stm_ia_done: got cycle %0d want 5", done_cycle);
    end
  endtask

  task automatic test_ldm_db();
    logic [31:0] ea [3];
    logic [3:0]  er [3];
    ea[0] = 32'h1FF4; ea[1] = 32'h1FF8; ea[2] = 32'h1FFC;
    er[0] = 4'd0; er[1] = 4'd1; er[2] = 4'd15;
    drive_op(16'h8003, 32'h2000, 4'd4, 2'b10, 1'b1, 1'b1, 0, 0, 1);
    checks++;
    if (beats.size() != 3) begin
      errors++; $display("FAIL ldm_db_beats: got %0d want 3", beats.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (beats[k].addr !== ea[k] || beats[k].we !== 1'b0 || beats[k].wen !== 1'b1 ||
            beats[k].wnum !== er[k] || beats[k].wrf !== 32'hA0 + 32'(k)) begin
          errors++;
          $display("FAIL ldm_db_beat%0d: addr=%h we=%b wen=%b R%0d=%h want addr=%h we=0 wen=1 R%0d=%h",
                   k, beats[k].addr, beats[k].we, beats[k].wen, beats[k].wnum, beats[k].wrf,
                   ea[k], er[k], 32'hA0 + 32'(k));
        end
      end
    end
    checks++;
    if (wbs.size() != 1 || wbs[0].num !== 4'd4 || wbs[0].data !== 32'h1FF4) begin
      errors++;
      $display("FAIL ldm_db_wb: writes=%0d want 1 write R4=00001ff4", wbs.size());
    end
    checks++;
    if (done_cycle != 5 || timed_out) begin
      errors++; $display("FAIL ldm_db_done: got cycle %0d want 5", done_cycle);
    end
  endtask

  task automatic test_ldm_base_in_list();
    drive_op(16'h0006, 32'h3000, 4'd2, 2'b01, 1'b1, 1'b1, 0, 0, 0);
    checks++;
    if (beats.size() != 2 || beats[1].wnum !== 4'd2 || beats[1].wrf !== beats[1].rdata ||
        beats[0].wnum !== 4'd1 || beats[1].addr !== 32'h3004) begin
      errors++;
      $display("FAIL ldm_base_load: beats=%0d want R1@3000,R2@3004 with loaded data", beats.size());
    end
    checks++;
    if (wbs.size() != 0) begin
      errors++; $display("FAIL ldm_base_no_wb: got %0d writes want 0", wbs.size());
    end
    checks++;
    if (done_cycle != 3 || timed_out) begin
      errors++; $display("FAIL ldm_base_done: got cycle %0d want 3", done_cycle);
    end
  endtask

  task automatic test_stm_ib_stall();
    rf_mem[0] = 32'hCAFE_0000;
    drive_op(16'h0001, 32'h4000, 4'd9, 2'b11, 1'b0, 1'b0, 2, 1, 0);
    checks++;
    if (beats.size() != 1 || beats[0].addr !== 32'h4004 || beats[0].wdata !== 32'hCAFE_0000 ||
        beats[0].we !== 1'b1) begin
      errors++;
      $display("FAIL stm_ib_beat: beats=%0d addr=%h want 1 beat at 00004004 data cafe0000",
               beats.size(), beats.size() > 0 ? beats[0].addr : 32'h0);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL stm_ib_hold: got %0d unstable stalls want 0", unstable);
    end
    checks++;
    if (req_cycles != 3) begin
      errors++; $display("FAIL stm_ib_req: got %0d request cycles want 3", req_cycles);
    end
    checks++;
    if (wbs.size() != 0 || done_cycle != 4 || done_count != 1 || timed_out) begin
      errors++;
      $display("FAIL stm_ib_done: writes=%0d done=%0d count=%0d want 0, 4, 1",
               wbs.size(), done_cycle, done_count);
    end
  endtask

  task automatic test_empty();
    drive_op(16'h0000, 32'h5000, 4'd1, 2'b01, 1'b1, 1'b1, 0, 0, 0);
    checks++;
    if (req_cycles != 0 || beats.size() != 0 || wbs.size() != 0) begin
      errors++;
      $display("FAIL empty_quiet: req=%0d beats=%0d writes=%0d want 0,0,0",
               req_cycles, beats.size(), wbs.size());
    end
    checks++;
    if (done_cycle != 1 || busy_cycles != 1 || busy_after !== 1'b0 || timed_out) begin
      errors++;
      $display("FAIL empty_done: done=%0d busy_cycles=%0d busy_after=%b want 1,1,0",
               done_cycle, busy_cycles, busy_after);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clock);
    reg_list = 16'h00F0; base_addr = 32'h6000; base_reg = 4'd3; mode = 2'b01;
    is_load = 1'b1; wb_en = 1'b1; start = 1'b1; mem_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h6004) begin
      errors++; $display("FAIL rmid_beat2: req=%b addr=%h want 1 00006004", mem_req, mem_addr);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, rf_write_en, done} !== 4'b0) begin
      errors++;
      $display("FAIL rmid_abort: req/busy/wen/done=%b want 0000", {mem_req, busy, rf_write_en, done});
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      if (mem_req || rf_write_en || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rmid_quiet: got %0d active cycles want 0", bad);
    end
    mem_ready = 1'b0;
    drive_op(16'h00F0, 32'h6000, 4'd3, 2'b01, 1'b1, 1'b1, 0, 0, 0);
    checks++;
    if (beats.size() != 4 || beats[0].addr !== 32'h6000 || beats[0].wnum !== 4'd4 ||
        wbs.size() != 1 || wbs[0].data !== 32'h6010 || done_cycle != 6) begin
      errors++;
      $display("FAIL rmid_rerun: beats=%0d writes=%0d done=%0d want 4 beats, R3=00006010, done 6",
               beats.size(), wbs.size(), done_cycle);
    end
  endtask

  task automatic test_random();
    logic [15:0] lst;
    logic [31:0] base, st, fin;
    logic [3:0]  breg;
    logic [1:0]  md;
    logic        ld, wb, exp_wb;
    int          n, stall, exp_done, k;
    int          regs[$];
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
      lst   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      base  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      breg  = 4'($urandom_range(0, 15));
      md    = 2'($urandom_range(0, 3));
      ld    = 1'($urandom_range(0, 1));
      wb    = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 1);
      regs.delete();
      for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(i);
      n      = regs.size();
      st     = model_start(base, md, n);
      fin    = model_final(base, md, n);
      exp_wb = (n > 0) && wb && !(ld && lst[breg]);
      drive_op(lst, base, breg, md, ld, wb, stall, 0, 0);
      checks++;
      if (beats.size() != n) begin
        errors++;
        $display("FAIL rnd%0d_beats: got %0d want %0d (list=%h)", t, beats.size(), n, lst);
      end else begin
        for (k = 0; k < n; k++) begin
          checks++;
          if (beats[k].addr !== st + 32'(4 * k) || beats[k].rnum !== 4'(regs[k]) ||
              beats[k].we !== !ld ||
              (!ld && (beats[k].wdata !== rf_mem[regs[k]] || beats[k].wen !== 1'b0)) ||
              (ld && (beats[k].wen !== 1'b1 || beats[k].wnum !== 4'(regs[k]) ||
                      beats[k].wrf !== beats[k].rdata))) begin
            errors++;
            $display("FAIL rnd%0d_beat%0d: addr=%h reg=%0d we=%b wen=%b want addr=%h reg=%0d we=%b",
                     t, k, beats[k].addr, beats[k].rnum, beats[k].we, beats[k].wen,
                     st + 32'(4 * k), regs[k], !ld);
          end
        end
      end
      checks++;
      if (wbs.size() != (exp_wb ? 1 : 0) ||
          (exp_wb && (wbs[0].num !== breg || wbs[0].data !== fin))) begin
        errors++;
        $display("FAIL rnd%0d_wb: writes=%0d want %0d (R%0d=%h)", t, wbs.size(), exp_wb, breg, fin);
      end
      exp_done = (n == 0) ? 1 : last_hs + (exp_wb ? 2 : 1);
      checks++;
      if (timed_out || done_cycle != exp_done || done_count != 1 || busy_cycles != exp_done ||
          busy_after !== 1'b0 || unstable != 0) begin
        errors++;
        $display("FAIL rnd%0d_timing: done=%0d cnt=%0d busy=%0d after=%b unstable=%0d want done=%0d",
                 t, done_cycle, done_count, busy_cycles, busy_after, unstable, exp_done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    reset = 1'b1;
    test_reset();
    test_stm_ia();
    test_ldm_db();
    test_ldm_base_in_list();
    test_stm_ib_stall();
    test_empty();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
